// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// frame geometry and the baud divisor computation.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int BITS_PER_BYTE = 8;
    localparam int FRAME_BITS    = 10;  // start + 8 data + stop

    // Clock cycles per bit time, truncated. Callers must keep the result >= 4.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time generator: emits a one-cycle tick on the last cycle of every
// DIV-cycle bit period. clr restarts the period so the first bit of a frame
// is exactly DIV cycles long.
module uart_baud_tick #(
    parameter int DIV = 16
) (
    input  logic CLK,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..DIV-1 and wrap on each bit boundary; clr forces a fresh period.
    always_ff @(posedge CLK) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_frame_tx.sv
// Sample serializer: on a rising edge of rdy while idle, sends the 24-bit
// sample (optionally preceded by a header byte) as back-to-back 8N1 bytes,
// MSB byte first, LSB bit first. tx and ready come straight from flops.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int          CLK_HZ    = 50_000_000,
    parameter int          BAUD      = 115200,
    parameter int          HEADER_EN = 0,
    parameter logic [7:0]  HEADER    = 8'hAA
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [23:0] data_in,
    input  logic        rdy,
    output logic        tx,
    output logic        ready
);

    localparam int         DIV      = calc_div(CLK_HZ, BAUD);
    localparam logic [2:0] BYTES    = 3'(3 + HEADER_EN);
    localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

    tx_state_t   state, state_next;
    logic [23:0] shift_q, shift_next;
    logic [2:0]  byte_cnt, byte_cnt_next;
    logic [2:0]  bit_cnt, bit_cnt_next;
    logic        tx_next;
    logic        ready_next;
    logic        rdy_q;
    logic        load;
    logic        tick;
    logic        header_phase;
    logic [7:0]  cur_byte;

    // A request is only the rising edge of rdy, and only while idle.
    assign load = rdy & ~rdy_q & ready;

    // The header is the first byte of a frame, so it is in flight while the
    // byte counter still holds its load value.
    assign header_phase = (HEADER_EN != 0) && (byte_cnt == BYTES);
    assign cur_byte     = header_phase ? HEADER : shift_q[23:16];

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .CLK   (CLK),
        .reset (reset),
        .clr   (load),
        .tick  (tick)
    );

    // State and datapath registers; reset parks the line idle-high.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= IDLE;
            shift_q  <= '0;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            ready    <= 1'b1;
            rdy_q    <= 1'b0;
        end else begin
            state    <= state_next;
            shift_q  <= shift_next;
            byte_cnt <= byte_cnt_next;
            bit_cnt  <= bit_cnt_next;
            tx       <= tx_next;
            ready    <= ready_next;
            rdy_q    <= rdy;
        end
    end

    // Next-state, next-line-level and datapath updates, advanced on bit ticks.
    always_comb begin
        // NOTE: every output gets a hold default before the case so no path
        // leaves a variable unassigned, which would infer a latch.
        state_next    = state;
        shift_next    = shift_q;
        byte_cnt_next = byte_cnt;
        bit_cnt_next  = bit_cnt;
        tx_next       = tx;
        ready_next    = ready;

        case (state)
            IDLE: begin
                if (load) begin
                    state_next    = START;
                    shift_next    = data_in;
                    byte_cnt_next = BYTES;
                    bit_cnt_next  = '0;
                    tx_next       = 1'b0;
                    ready_next    = 1'b0;
                end
            end

            START: begin
                if (tick) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                    tx_next      = cur_byte[0];
                end
            end

            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                        tx_next      = cur_byte[bit_cnt + 3'd1];
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    byte_cnt_next = byte_cnt - 3'd1;
                    if (!header_phase) begin
                        shift_next = {shift_q[15:0], 8'h00};
                    end
                    if (byte_cnt != 3'd1) begin
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        ready_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                ready_next = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx with DIV=16: one instance without header, one with
// header 0xAA. Expected line waveforms come from a byte-list model that
// expands each byte into start/data/stop cells of DIV cycles.
module tb_uart_frame_tx;

    localparam int DIV  = 16;
    localparam int MAXN = 2600;

    logic        CLK = 1'b0;
    logic        reset;
    logic        rdy0, rdy1;
    logic [23:0] data0, data1;
    logic        tx0, tx1, ready0, ready1;

    always #5 CLK = ~CLK;

    uart_frame_tx #(.CLK_HZ(16), .BAUD(1), .HEADER_EN(0), .HEADER(8'hAA)) dut0 (
        .CLK(CLK), .reset(reset), .data_in(data0), .rdy(rdy0), .tx(tx0), .ready(ready0)
    );

    uart_frame_tx #(.CLK_HZ(16), .BAUD(1), .HEADER_EN(1), .HEADER(8'hAA)) dut1 (
        .CLK(CLK), .reset(reset), .data_in(data1), .rdy(rdy1), .tx(tx1), .ready(ready1)
    );

    int total = 0;
    int bad   = 0;

    bit         obs_tx  [MAXN];
    bit         obs_rdy [MAXN];
    bit         exp_tx  [MAXN];
    int         exp_len;
    logic [7:0] exp_bytes[$];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input bit hdr, input bit r, input logic [23:0] d);
        if (hdr) begin
            rdy1  = r;
            data1 = d;
        end else begin
            rdy0  = r;
            data0 = d;
        end
    endtask

    function automatic bit cur_tx(input bit hdr);
        return hdr ? tx1 : tx0;
    endfunction

    function automatic bit cur_ready(input bit hdr);
        return hdr ? ready1 : ready0;
    endfunction

    // Reference model: byte list -> expected line level per cycle from the
    // first start-bit cycle onward, idle high after the frame.
    function automatic void build_model(input bit hdr, input logic [23:0] d);
        exp_bytes.delete();
        if (hdr) exp_bytes.push_back(8'hAA);
        exp_bytes.push_back(d[23:16]);
        exp_bytes.push_back(d[15:8]);
        exp_bytes.push_back(d[7:0]);
        exp_len = exp_bytes.size() * 10 * DIV;
        for (int i = 0; i < MAXN; i++) exp_tx[i] = 1'b1;
        for (int k = 0; k < exp_bytes.size(); k++) begin
            logic [7:0] byt;
            byt = exp_bytes[k];
            for (int b = 0; b < 10; b++) begin
                bit v;
                v = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : byt[b-1];
                for (int c = 0; c < DIV; c++) exp_tx[(k * 10 + b) * DIV + c] = v;
            end
        end
    endfunction

    // Issue a request and record n cycles of tx/ready. hold keeps rdy high;
    // glitch_at >= 0 raises a fresh rdy edge after that recorded cycle.
    // data_in is scrambled after the request to catch a non-latching design.
    task automatic run_frame(input bit hdr, input logic [23:0] d, input int n,
                             input bit hold, input int glitch_at);
        build_model(hdr, d);
        drive(hdr, 1'b1, d);
        for (int i = 0; i < n; i++) begin
            step();
            obs_tx[i]  = cur_tx(hdr);
            obs_rdy[i] = cur_ready(hdr);
            if (glitch_at >= 0 && i == glitch_at) drive(hdr, 1'b1, 24'($urandom));
            else                                  drive(hdr, hold, 24'($urandom));
        end
        drive(hdr, 1'b0, 24'($urandom));
    endtask

    // Compare the recorded n cycles against the model.
    task automatic score_frame(input string label, input int n);
        int mm;
        int low;
        for (int k = 0; k < exp_bytes.size(); k++) begin
            logic [9:0] got;
            logic [9:0] want;
            int base;
            base = k * 10 * DIV;
            for (int b = 0; b < 10; b++) got[b] = obs_tx[base + b * DIV + DIV / 2];
            want = {1'b1, exp_bytes[k], 1'b0};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s byte%0d: line frame {stop,data,start}=%b, required %b", label, k, got, want);
            end
        end
        mm = 0;
        low = 0;
        for (int i = 0; i < n; i++) begin
            if (obs_tx[i] != exp_tx[i]) mm++;
            if (!obs_rdy[i]) low++;
        end
        total++;
        if (mm != 0) begin
            bad++;
            $display("FAIL %s waveform: %0d cycles of tx differ from model, required 0", label, mm);
        end
        total++;
        if (low != exp_len) begin
            bad++;
            $display("FAIL %s ready_low: ready low %0d cycles, required %0d", label, low, exp_len);
        end
        total++;
        if (obs_rdy[0] !== 1'b0 || obs_rdy[exp_len-1] !== 1'b0 || obs_rdy[exp_len] !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_edges: ready first=%0b last=%0b after=%0b, required 0 0 1",
                     label, obs_rdy[0], obs_rdy[exp_len-1], obs_rdy[exp_len]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 24'h0);
        drive(1'b1, 1'b0, 24'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (tx0 !== 1'b1 || ready0 !== 1'b1 || tx1 !== 1'b1 || ready1 !== 1'b1) begin
                bad++;
                $display("FAIL reset_cycle%0d: tx0=%b ready0=%b tx1=%b ready1=%b, required all 1",
                         i, tx0, ready0, tx1, ready1);
            end
        end
        reset = 1'b0;
        begin
            int dev;
            dev = 0;
            for (int i = 0; i < 100; i++) begin
                step();
                if (tx0 !== 1'b1 || ready0 !== 1'b1 || tx1 !== 1'b1 || ready1 !== 1'b1) dev++;
            end
            total++;
            if (dev != 0) begin
                bad++;
                $display("FAIL reset_idle: %0d non-idle cycles after reset, required 0", dev);
            end
        end
    endtask

    task automatic test_single();
        run_frame(1'b0, 24'h123456, 520, 1'b0, -1);
        score_frame("single_123456", 520);
    endtask

    task automatic test_header();
        run_frame(1'b1, 24'hFF00A5, 680, 1'b0, -1);
        score_frame("header_FF00A5", 680);
    endtask

    task automatic test_level();
        run_frame(1'b0, 24'h000001, 2000, 1'b1, -1);
        score_frame("level_hold", 2000);
        repeat (5) step();
    endtask

    task automatic test_back_to_back();
        logic [23:0] d1, d2;
        d1 = 24'($urandom);
        d2 = 24'($urandom);
        // Edge at cycle 200 is dropped; recording stops in the cycle ready
        // reads 1 and the next request is raised in that same cycle.
        run_frame(1'b0, d1, 481, 1'b0, 199);
        score_frame("ignored_edge", 481);
        run_frame(1'b0, d2, 500, 1'b0, -1);
        score_frame("back_to_back", 500);
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 24'($urandom));
        step();
        drive(1'b0, 1'b0, 24'($urandom));
        repeat (248) step();
        total++;
        if (ready0 !== 1'b0) begin
            bad++;
            $display("FAIL mid_active: ready=%b before reset, required 0", ready0);
        end
        reset = 1'b1;
        step();
        total++;
        if (tx0 !== 1'b1 || ready0 !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: tx=%b ready=%b after reset edge, required 1 1", tx0, ready0);
        end
        reset = 1'b0;
        step();
        run_frame(1'b0, 24'hABCDEF, 520, 1'b0, -1);
        score_frame("after_reset_ABCDEF", 520);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            bit          hdr;
            logic [23:0] d;
            hdr = 1'($urandom_range(0, 1));
            d   = 24'($urandom);
            run_frame(hdr, d, 700, 1'b0, -1);
            score_frame($sformatf("random%0d_h%0d_%h", r, hdr, d), 700);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_header();
        test_level();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
